cpu_clk_ctrl: RTL and testbench

Clock-control stage sitting directly downstream of the free-running clock generator: it consumes the raw `CLK` and produces the processor's clock-enable and core reset. It sequences a power-on reset hold, then runs the RV32I core in halt, free-run, or single-step mode. In free-run mode the enable rate is set by a programmable divider. All core flops gate on `CPU_EN`, so the design stays single-clock.

---
 rtl/cpu_clk_ctrl_pkg.sv | 22 ++
 rtl/cpu_clk_ctrl_if.sv | 48 ++++
 rtl/cpu_clk_ctrl_clk_prescaler.sv | 39 +++
 rtl/cpu_clk_ctrl.sv | 121 ++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// cpu_clk_ctrl_pkg
// Shared definitions for the CPU clock-control stage: the FSM state
// encoding and its width. The debug front end that decodes STATE imports
// this package too, so the encodings here must stay stable.
// Optional feature macro used elsewhere in this slice: CPU_CLK_CYCLE_COUNTER_EN.
package cpu_clk_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_RST  = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_e;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int rst_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// cpu_clk_ctrl_if
// Bundles the request inputs and the clock-control outputs of cpu_clk_ctrl.
//   master modport : the debugger/core side (drives RUN/STEP/HALT/BREAK/DIV)
//   slave modport  : cpu_clk_ctrl itself (drives CPU_EN/CPU_RST_N/HALTED/STATE)
// Handshake: there is no valid/ready pair; every request input is a level
// sampled on each rising CLK edge, and every output is registered or decoded
// purely from registers, so it is stable for the whole cycle.
// With CPU_CLK_CYCLE_COUNTER_EN defined the bundle also carries CYCLES
// (CNT_W bits, count of CPU_EN pulses).
interface cpu_clk_ctrl_if
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_W = 8
`ifdef CPU_CLK_CYCLE_COUNTER_EN
  , parameter int CNT_W = 32
`endif
);

  logic               RUN;
  logic               STEP;
  logic               HALT;
  logic               BREAK;
  logic [DIV_W-1:0]   DIV;
  logic               CPU_EN;
  logic               CPU_RST_N;
  logic               HALTED;
  logic [STATE_W-1:0] STATE;
`ifdef CPU_CLK_CYCLE_COUNTER_EN
  logic [CNT_W-1:0]   CYCLES;
`endif

  modport master (
    output RUN, STEP, HALT, BREAK, DIV,
`ifdef CPU_CLK_CYCLE_COUNTER_EN
    input  CYCLES,
`endif
    input  CPU_EN, CPU_RST_N, HALTED, STATE
  );

  modport slave (
    input  RUN, STEP, HALT, BREAK, DIV,
`ifdef CPU_CLK_CYCLE_COUNTER_EN
    output CYCLES,
`endif
    output CPU_EN, CPU_RST_N, HALTED, STATE
  );

endinterface

// File: rtl/cpu_clk_ctrl_clk_prescaler.sv
// clk_prescaler
// Programmable up-counter that divides the clock by (shadow + 1).
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   load       : clear the count to 0 and capture div into the shadow
//   cnt_en     : advance the count (0..shadow, then wrap to 0)
//   div        : divide setting, only looked at while load is high
//   tick       : high while count == shadow, decoded from flops only
module clk_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             cnt_en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] shadow;

  // The shadow isolates the running period from DIV changes until the
  // next load, so a mid-run DIV write cannot shorten a period in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      shadow <= '0;
    end else if (load) begin
      count  <= '0;
      shadow <= div;
    end else if (cnt_en) begin
      count <= tick ? '0 : count + DIV_W'(1);
    end
  end

  assign tick = (count == shadow);

endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl
// Clock-control stage for the RV32I core. After RST_N releases it holds the
// core in reset for RST_CYCLES cycles, then parks in halt and serves
// run / single-step / halt requests. The core stays on CLK and gates its
// flops with CPU_EN, whose rate in run mode is set by DIV (one pulse every
// DIV+1 cycles).
// Ports:
//   CLK   : single rising-edge clock
//   RST_N : synchronous active-low reset
//   bus   : cpu_clk_ctrl_if.slave (RUN, STEP, HALT, BREAK, DIV in;
//           CPU_EN, CPU_RST_N, HALTED, STATE out; CYCLES out when
//           CPU_CLK_CYCLE_COUNTER_EN is defined)
// Optional feature macro: CPU_CLK_CYCLE_COUNTER_EN adds the CNT_W-bit
// CPU_EN pulse counter CYCLES, cleared only by RST_N.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_W      = 8,
  parameter int RST_CYCLES = 16
`ifdef CPU_CLK_CYCLE_COUNTER_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic                CLK,
  input  logic                RST_N,
  cpu_clk_ctrl_if.slave       bus
);

  localparam int RC_W = rst_cnt_w(RST_CYCLES);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  state_e          state_q;
  state_e          state_d;
  logic [RC_W-1:0] rst_cnt_q;
  logic            cpu_rst_n_q;
  logic            presc_load;
  logic            presc_cnt_en;
  logic            tick;
  logic            stop_req;
  logic            cpu_en;

  assign stop_req = bus.HALT | bus.BREAK;

  // Next-state logic. Requests are ignored while the core is in reset.
  always_comb begin
    state_d    = state_q;
    presc_load = 1'b0;
    unique case (state_q)
      S_RST: begin
        if (rst_cnt_q == RC_LAST) state_d = S_HALT;
      end
      S_HALT: begin
        if (stop_req) begin
          state_d = S_HALT;
        end else if (bus.STEP) begin
          state_d    = S_STEP;
          presc_load = 1'b1;
        end else if (bus.RUN) begin
          state_d    = S_RUN;
          presc_load = 1'b1;
        end
      end
      S_RUN: begin
        if (stop_req) state_d = S_HALT;
      end
      S_STEP: begin
        // A stop before the pulse aborts the step; otherwise the cycle that
        // carries the single pulse is the last one spent here.
        if (stop_req || tick) state_d = S_HALT;
      end
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_RST;
      rst_cnt_q   <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (state_q == S_RST) rst_cnt_q <= rst_cnt_q + RC_W'(1);
      // Released on the same edge that leaves S_RST.
      cpu_rst_n_q <= (state_d != S_RST);
    end
  end

  assign presc_cnt_en = (state_q == S_RUN) || (state_q == S_STEP);

  clk_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (CLK),
    .rst_n  (RST_N),
    .load   (presc_load),
    .cnt_en (presc_cnt_en),
    .div    (bus.DIV),
    .tick   (tick)
  );

  // Flop-only decode: a HALT in a pulse cycle cannot cut that pulse short.
  assign cpu_en = presc_cnt_en & tick;

  assign bus.CPU_EN    = cpu_en;
  assign bus.CPU_RST_N = cpu_rst_n_q;
  assign bus.HALTED    = (state_q == S_HALT);
  assign bus.STATE     = state_q;

`ifdef CPU_CLK_CYCLE_COUNTER_EN
  logic [CNT_W-1:0] cycles_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cycles_q <= '0;
    end else if (cpu_en) begin
      cycles_q <= cycles_q + CNT_W'(1);
    end
  end

  assign bus.CYCLES = cycles_q;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl
// Directed bench for cpu_clk_ctrl (DIV_W=8, RST_CYCLES=16; CNT_W=4 when
// CPU_CLK_CYCLE_COUNTER_EN is defined). A table of per-cycle request vectors
// with hand-computed outputs drives the mode transitions; hand-written
// sequences cover reset release, halt in a pulse cycle, mid-run reset and
// the CYCLES wrap.
module tb_cpu_clk_ctrl;
  import cpu_clk_ctrl_pkg::*;

  localparam int DIV_W      = 8;
  localparam int RST_CYCLES = 16;
`ifdef CPU_CLK_CYCLE_COUNTER_EN
  localparam int CNT_W      = 4;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef CPU_CLK_CYCLE_COUNTER_EN
  cpu_clk_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();
  cpu_clk_ctrl #(.DIV_W(DIV_W), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );
`else
  cpu_clk_ctrl_if #(.DIV_W(DIV_W)) bus ();
  cpu_clk_ctrl #(.DIV_W(DIV_W), .RST_CYCLES(RST_CYCLES)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );
`endif

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int exp_cycles = 0;

  typedef struct {
    logic             run;
    logic             step;
    logic             halt;
    logic             brk;
    logic [DIV_W-1:0] div;
    logic             exp_en;
    logic             exp_halted;
    logic [1:0]       exp_state;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cycles(input string name);
`ifdef CPU_CLK_CYCLE_COUNTER_EN
    chk(name, 32'(bus.CYCLES), 32'(exp_cycles % (1 << CNT_W)));
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic run, input logic step, input logic halt,
                       input logic brk, input logic [DIV_W-1:0] div);
    bus.RUN   = run;
    bus.STEP  = step;
    bus.HALT  = halt;
    bus.BREAK = brk;
    bus.DIV   = div;
  endtask

  task automatic add_vec(input logic run, input logic step, input logic halt,
                         input logic brk, input logic [DIV_W-1:0] div,
                         input logic en, input logic halted, input logic [1:0] st);
    vec_t v;
    v.run = run; v.step = step; v.halt = halt; v.brk = brk; v.div = div;
    v.exp_en = en; v.exp_halted = halted; v.exp_state = st;
    vecs.push_back(v);
  endtask

  task automatic chk_outputs(input string tag, input logic en, input logic crst,
                             input logic halted, input logic [1:0] st);
    chk({tag, "_en"},     32'(bus.CPU_EN),    32'(en));
    chk({tag, "_rstn"},   32'(bus.CPU_RST_N), 32'(crst));
    chk({tag, "_halted"}, 32'(bus.HALTED),    32'(halted));
    chk({tag, "_state"},  32'(bus.STATE),     32'(st));
  endtask

  // RST_N low for 3 edges, then release; RUN pulsed at edge 5 must be ignored.
  task automatic reset_sequence(input string tag);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_outputs($sformatf("%s_hold%0d", tag, i), 1'b0, 1'b0, 1'b0, 2'd0);
    end
    exp_cycles = 0;
    chk_cycles({tag, "_cycles_clr"});
    rst_n = 1'b1;
    for (int e = 0; e < RST_CYCLES; e++) begin
      drive(e == 5, 1'b0, 1'b0, 1'b0, '0);
      tick();
      if (e < RST_CYCLES - 1)
        chk_outputs($sformatf("%s_e%0d", tag, e), 1'b0, 1'b0, 1'b0, 2'd0);
      else
        chk_outputs($sformatf("%s_e%0d", tag, e), 1'b0, 1'b1, 1'b1, 2'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // ---------------- test ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);

    //       run  step halt brk  div   en   hlt  state
    // free run, DIV=0; STEP ignored while running
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 2'd2);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 2'd2);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 2'd2);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 2'd1);
    // divide by 4 (DIV=3); DIV changed to 1 mid-run keeps the period at 4
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 2'd2);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 2'd2);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 2'd2);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 2'd2);
    for (int r = 0; r < 2; r++) begin
      add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 2'd2);
      add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 2'd2);
      add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 2'd2);
      add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 2'd2);
    end
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 2'd1);
    // single step, DIV=2: one pulse at k+3, then back to halt
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 2'd3);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 2'd3);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 2'd3);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 2'd1);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 2'd1);
    // STEP+RUN together -> step wins; DIV=0 gives the pulse immediately
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 2'd3);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 2'd1);
    // BREAK during run
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 2'd2);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b1, 2'd1);
    // HALT beats STEP in halt
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 2'd1);
    // HALT aborts a step before its pulse (DIV=4)
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 2'd3);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b1, 2'd1);
    for (int r = 0; r < 5; r++)
      add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 2'd1);

    reset_sequence("rst1");

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].run, vecs[i].step, vecs[i].halt, vecs[i].brk, vecs[i].div);
      tick();
      chk_outputs($sformatf("vec%0d", i), vecs[i].exp_en, 1'b1,
                  vecs[i].exp_halted, vecs[i].exp_state);
      chk_cycles($sformatf("vec%0d_cycles", i));
      if (vecs[i].exp_en) exp_cycles++;
    end

    // HALT raised during a pulse cycle leaves that pulse intact (DIV=1)
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    tick();
    chk_outputs("hp0", 1'b0, 1'b1, 1'b0, 2'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    tick();
    chk_outputs("hp1", 1'b1, 1'b1, 1'b0, 2'd2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    #1;
    chk("hp_same_cycle_en", 32'(bus.CPU_EN), 32'd1);
    tick();
    exp_cycles++;
    chk_outputs("hp2", 1'b0, 1'b1, 1'b1, 2'd1);
    chk_cycles("hp_cycles");

    // mid-run reset, DIV=0
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    chk_outputs("mr_run", 1'b1, 1'b1, 1'b0, 2'd2);
    rst_n = 1'b0;
    tick();
    chk_outputs("mr_rst", 1'b0, 1'b0, 1'b0, 2'd0);
    exp_cycles = 0;
    chk_cycles("mr_cycles");

    reset_sequence("rst2");

    // 17 pulses at DIV=0: CYCLES wraps to 1 with a 4-bit counter
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 16; i++) tick();
    chk_outputs("wrap_run", 1'b1, 1'b1, 1'b0, 2'd2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    tick();
    exp_cycles = 17;
    chk_outputs("wrap_halt", 1'b0, 1'b1, 1'b1, 2'd1);
    chk_cycles("wrap_cycles");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
